fc2_bias_add_join: RTL and testbench

//  Bias-add stage of the fc2 linear layer. Joins the matmul accumulator stream (data_in) with the

---
 rtl/fc2_bias_add_join.sv | 122 ++++++++++++
 tb/tb_fc2_bias_add_join.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc2_bias_add_join.sv
// fc2 bias-add join stage.
// Pairs one accumulator beat with one bias beat, aligns the bias to the
// accumulator's fixed-point format and adds the two. The sum is rescaled to the
// output format by flooring, saturated, and registered. A one-entry skid behind
// the output register lets the upstream ready come from a flop rather than from
// the downstream ready.
//
// Handshake: a beat moves across an interface on a clock edge where its valid and
// ready are both high. A producer holds valid and data stable until that edge.
// Ready may rise without valid, except for bias_ready, which is only high while
// data_in_valid is high, because the bias source advances on bias_ready alone.
module fc2_bias_add_join #(
  parameter int DATA_IN_PRECISION_0  = 32,
  parameter int DATA_IN_PRECISION_1  = 8,
  parameter int BIAS_PRECISION_0     = 16,
  parameter int BIAS_PRECISION_1     = 3,
  parameter int DATA_OUT_PRECISION_0 = 16,
  parameter int DATA_OUT_PRECISION_1 = 3,
  parameter int PARALLELISM          = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DATA_IN_PRECISION_0*PARALLELISM-1:0]    data_in,
  input  logic                                          data_in_valid,
  output logic                                          data_in_ready,
  input  logic [BIAS_PRECISION_0*PARALLELISM-1:0]       bias,
  input  logic                                          bias_valid,
  output logic                                          bias_ready,
  output logic [DATA_OUT_PRECISION_0*PARALLELISM-1:0]   data_out,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready,
  output logic                                          sat_seen
);

  localparam int DIN_W  = DATA_IN_PRECISION_0;
  localparam int BIAS_W = BIAS_PRECISION_0;
  localparam int OUT_W  = DATA_OUT_PRECISION_0;
  // One guard bit above the accumulator width: the aligned add cannot overflow.
  localparam int SUM_W  = DIN_W + 1;
  // Left shift that brings the bias onto the accumulator's binary point.
  localparam int SH_B   = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
  // Right shift that drops the extra fractional bits of the output format.
  localparam int SH_O   = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1;

  // Output range expressed at the sum width so the clamp compares like with like.
  localparam logic signed [SUM_W-1:0] OUT_MAX =
    {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN =
    {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                            skid_valid;
  logic [OUT_W*PARALLELISM-1:0]    skid_data;
  logic [OUT_W*PARALLELISM-1:0]    result;
  logic [PARALLELISM-1:0]          lane_sat;
  logic                            in_ready;
  logic                            fire;
  logic                            out_free;

  // Upstream readiness depends only on the registered skid state.
  assign in_ready      = !skid_valid;
  assign fire          = data_in_valid & bias_valid & in_ready;
  assign data_in_ready = bias_valid & in_ready;
  assign bias_ready    = data_in_valid & in_ready;
  // Output register can take a new beat this cycle.
  assign out_free      = !data_out_valid | data_out_ready;

  for (genvar j = 0; j < PARALLELISM; j++) begin : g_lane
    logic signed [SUM_W-1:0] d_ext;
    logic signed [SUM_W-1:0] b_ext;
    logic signed [SUM_W-1:0] b_al;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sh;
    logic                    hi;
    logic                    lo;

    assign d_ext = {{(SUM_W-DIN_W){data_in[j*DIN_W+DIN_W-1]}}, data_in[j*DIN_W +: DIN_W]};
    assign b_ext = {{(SUM_W-BIAS_W){bias[j*BIAS_W+BIAS_W-1]}}, bias[j*BIAS_W +: BIAS_W]};
    assign b_al  = b_ext <<< SH_B;
    assign sum   = d_ext + b_al;
    // Arithmetic shift of a signed value floors towards minus infinity.
    assign sh    = sum >>> SH_O;
    assign hi    = sh > OUT_MAX;
    assign lo    = sh < OUT_MIN;

    assign lane_sat[j] = hi | lo;
    assign result[j*OUT_W +: OUT_W] = hi ? OUT_MAX[OUT_W-1:0] :
                                      lo ? OUT_MIN[OUT_W-1:0] :
                                           sh[OUT_W-1:0];
  end

  // Output register, skid entry and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      skid_valid     <= 1'b0;
      skid_data      <= '0;
      sat_seen       <= 1'b0;
    end else begin
      if (fire && (|lane_sat)) begin
        sat_seen <= 1'b1;
      end
      if (fire && out_free) begin
        // New beat goes straight to the output register.
        data_out       <= result;
        data_out_valid <= 1'b1;
      end else if (fire) begin
        // Output is stalled: park the beat; in_ready drops next cycle.
        skid_data  <= result;
        skid_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        if (skid_valid) begin
          data_out   <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          data_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc2_bias_add_join.sv
// Testbench for fc2_bias_add_join: directed vectors plus a randomized stream
// checked against an arithmetic reference model through an expected queue.
module tb_fc2_bias_add_join;

  localparam int P      = 2;
  localparam int DW     = 32;
  localparam int BW     = 16;
  localparam int OW     = 16;
  localparam int DFRAC  = 8;
  localparam int BFRAC  = 3;
  localparam int OFRAC  = 3;
  localparam int NBEATS = 32;

  logic              clk;
  logic              rst;
  logic [P*DW-1:0]   data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [P*BW-1:0]   bias;
  logic              bias_valid;
  logic              bias_ready;
  logic [P*OW-1:0]   data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic              sat_seen;

  int errors = 0;
  int checks = 0;

  logic [P*OW-1:0] exp_q[$];
  bit              sat_model = 1'b0;
  bit              prev_hold = 1'b0;
  logic [P*OW-1:0] prev_data = '0;
  int              rx_count  = 0;

  fc2_bias_add_join #(
    .DATA_IN_PRECISION_0  (DW),
    .DATA_IN_PRECISION_1  (DFRAC),
    .BIAS_PRECISION_0     (BW),
    .BIAS_PRECISION_1     (BFRAC),
    .DATA_OUT_PRECISION_0 (OW),
    .DATA_OUT_PRECISION_1 (OFRAC),
    .PARALLELISM          (P)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .bias           (bias),
    .bias_valid     (bias_valid),
    .bias_ready     (bias_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .sat_seen       (sat_seen)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Real-valued semantics: value = raw / 2^frac. Sum in units of 2^-DFRAC,
  // convert to units of 2^-OFRAC by floor division, then clamp.
  function automatic logic [P*OW-1:0] model_beat(input logic [P*DW-1:0] d,
                                                 input logic [P*BW-1:0] b,
                                                 output bit sat);
    logic [P*OW-1:0] r;
    longint bscale;
    longint div;
    longint omax;
    longint omin;
    r      = '0;
    sat    = 1'b0;
    bscale = longint'(1) << (DFRAC - BFRAC);
    div    = longint'(1) << (DFRAC - OFRAC);
    omax   = (longint'(1) << (OW - 1)) - 1;
    omin   = -(longint'(1) << (OW - 1));
    for (int j = 0; j < P; j++) begin
      logic [DW-1:0] dl;
      logic [BW-1:0] bl;
      longint dv;
      longint bv;
      longint s;
      longint q;
      logic [63:0] qv;
      dl = d[j*DW +: DW];
      bl = b[j*BW +: BW];
      dv = longint'($signed(dl));
      bv = longint'($signed(bl));
      s  = dv + bv * bscale;
      q  = s / div;
      if ((s % div) != 0 && s < 0) q = q - 1;
      if (q > omax) begin q = omax; sat = 1'b1; end
      if (q < omin) begin q = omin; sat = 1'b1; end
      qv = q;
      r[j*OW +: OW] = qv[OW-1:0];
    end
    return r;
  endfunction

  // ---------------- scoreboard / protocol monitor ----------------
  // Samples on the falling edge, half a cycle away from the capturing edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sat_model = 1'b0;
      prev_hold = 1'b0;
    end else begin
      checks++;
      if (exp_q.size() > 2) begin
        errors++;
        $display("FAIL occupancy: beats in flight=%0d, allowed at most 2", exp_q.size());
      end
      checks++;
      if (data_out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b, expected %b (in flight=%0d)",
                 data_out_valid, exp_q.size() != 0, exp_q.size());
      end
      if (exp_q.size() == 2 && bias_valid === 1'b1) begin
        checks++;
        if (data_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_accept: data_in_ready=%b with out and skid full, expected 0", data_in_ready);
        end
      end
      checks++;
      if (bias_ready === 1'b1 && data_in_valid !== 1'b1) begin
        errors++;
        $display("FAIL bias_alone: bias_ready=1 while data_in_valid=%b", data_in_valid);
      end
      checks++;
      if (sat_seen !== sat_model) begin
        errors++;
        $display("FAIL sat_seen: got %b, expected %b", sat_seen, sat_model);
      end
      if (prev_hold) begin
        checks++;
        if (data_out !== prev_data) begin
          errors++;
          $display("FAIL hold: data_out changed under stall, got %h, expected %h", data_out, prev_data);
        end
      end
      if (data_out_valid === 1'b1 && data_out_ready === 1'b1 && exp_q.size() > 0) begin
        logic [P*OW-1:0] e;
        e = exp_q.pop_front();
        rx_count++;
        checks++;
        if (data_out !== e) begin
          errors++;
          $display("FAIL beat: got %h, expected %h", data_out, e);
        end
      end
      if (data_in_valid === 1'b1 && data_in_ready === 1'b1 &&
          bias_valid === 1'b1 && bias_ready === 1'b1) begin
        bit s;
        exp_q.push_back(model_beat(data_in, bias, s));
        sat_model = sat_model | s;
      end
      prev_hold = (data_out_valid === 1'b1) && (data_out_ready !== 1'b1);
      prev_data = data_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    v = $urandom();
    if ($urandom_range(0, 3) != 0) v = DW'($signed(v) >>> $urandom_range(6, 20));
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_bias();
    logic [BW-1:0] v;
    v = BW'($urandom());
    if ($urandom_range(0, 3) != 0) v = BW'($signed(v) >>> $urandom_range(2, 10));
    return v;
  endfunction

  // One beat with a directed lane 0 and a small non-saturating random lane 1.
  task automatic send_check(input logic [DW-1:0] d0, input logic [BW-1:0] b0,
                            input logic [OW-1:0] exp0, input logic exp_sat,
                            input string name);
    int d1;
    int b1;
    d1 = int'($urandom_range(0, 131071)) - 65536;
    b1 = int'($urandom_range(0, 2047)) - 1024;
    step();
    data_in        = {DW'(d1), d0};
    bias           = {BW'(b1), b0};
    data_in_valid  = 1'b1;
    bias_valid     = 1'b1;
    data_out_ready = 1'b1;
    step();
    data_in_valid = 1'b0;
    bias_valid    = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %b, expected 1", name, data_out_valid);
    end
    checks++;
    if (data_out[OW-1:0] !== exp0) begin
      errors++;
      $display("FAIL %s_data: got %h, expected %h", name, data_out[OW-1:0], exp0);
    end
    checks++;
    if (sat_seen !== exp_sat) begin
      errors++;
      $display("FAIL %s_sat: got %b, expected %b", name, sat_seen, exp_sat);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    data_in_valid  = 1'b0;
    bias_valid     = 1'b0;
    data_out_ready = 1'b1;
    data_in        = '0;
    bias           = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    bias_valid = 1'b1;
    #1;
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, expected 0", data_out_valid);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_data: got %h, expected 0", data_out);
    end
    checks++;
    if (sat_seen !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got %b, expected 0", sat_seen);
    end
    checks++;
    if (data_in_ready !== 1'b1 || bias_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: data_in_ready=%b bias_ready=%b, expected 1 and 0",
               data_in_ready, bias_ready);
    end
    bias_valid = 1'b0;
  endtask

  task automatic test_basic();
    send_check(32'h0000_0100, 16'h0010, 16'h0018, 1'b0, "basic");
  endtask

  task automatic test_floor();
    send_check(32'hFFFF_FFFF, 16'h0000, 16'hFFFF, 1'b0, "floor");
  endtask

  task automatic test_saturate();
    send_check(32'h7FFF_FF00, 16'h7FFF, 16'h7FFF, 1'b1, "sat_pos");
    send_check(32'h8000_0000, 16'h0000, 16'h8000, 1'b1, "sat_neg");
  endtask

  task automatic test_bias_only();
    bias       = {BW'(16'h0005), BW'(16'h0010)};
    for (int i = 0; i < 5; i++) begin
      step();
      bias_valid    = 1'b1;
      data_in_valid = 1'b0;
      #1;
      checks++;
      if (bias_ready !== 1'b0) begin
        errors++; $display("FAIL bias_only_ready: cycle %0d got %b, expected 0", i, bias_ready);
      end
      checks++;
      if (data_out_valid !== 1'b0) begin
        errors++; $display("FAIL bias_only_out: cycle %0d data_out_valid=%b, expected 0", i, data_out_valid);
      end
    end
    step();
    bias_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [P*DW-1:0] d_arr[NBEATS];
    logic [P*BW-1:0] b_arr[NBEATS];
    int  idx;
    int  rx_start;
    bit  fired;
    bit  done;
    for (int i = 0; i < NBEATS; i++) begin
      for (int j = 0; j < P; j++) begin
        d_arr[i][j*DW +: DW] = rand_data();
        b_arr[i][j*BW +: BW] = rand_bias();
      end
    end
    idx      = 0;
    rx_start = rx_count;
    fired    = 1'b0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      step();
      if (fired) begin
        data_in_valid = 1'b0;
        bias_valid    = 1'b0;
        idx++;
      end
      if (idx < NBEATS) begin
        if (!data_in_valid && $urandom_range(0, 3) != 0) begin
          data_in       = d_arr[idx];
          data_in_valid = 1'b1;
        end
        if (!bias_valid && $urandom_range(0, 3) != 0) begin
          bias       = b_arr[idx];
          bias_valid = 1'b1;
        end
      end
      data_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = data_in_valid && bias_valid && data_in_ready && bias_ready;
      if (rx_count - rx_start == NBEATS) done = 1'b1;
    end
    step();
    data_in_valid  = 1'b0;
    bias_valid     = 1'b0;
    data_out_ready = 1'b1;
    checks++;
    if (rx_count - rx_start != NBEATS) begin
      errors++;
      $display("FAIL stream_count: received %0d beats, expected %0d", rx_count - rx_start, NBEATS);
    end
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stream_drain: %0d beats still expected, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_full();
    step();
    data_out_ready = 1'b0;
    data_in        = {DW'(32'h0000_0100), DW'(32'h7FFF_FF00)};
    bias           = {BW'(16'h0001), BW'(16'h7FFF)};
    data_in_valid  = 1'b1;
    bias_valid     = 1'b1;
    step();
    data_in = {DW'(32'h0000_0200), DW'(32'h0000_0300)};
    bias    = {BW'(16'h0002), BW'(16'h0003)};
    step();
    #1;
    checks++;
    if (data_in_ready !== 1'b0 || data_out_valid !== 1'b1 || sat_seen !== 1'b1) begin
      errors++;
      $display("FAIL full_pre: in_ready=%b out_valid=%b sat=%b, expected 0 1 1",
               data_in_ready, data_out_valid, sat_seen);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL full_reset_out: valid=%b data=%h, expected 0 and 0", data_out_valid, data_out);
    end
    checks++;
    if (sat_seen !== 1'b0) begin
      errors++; $display("FAIL full_reset_sat: got %b, expected 0", sat_seen);
    end
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++; $display("FAIL full_reset_ready: got %b, expected 1", data_in_ready);
    end
    data_in_valid  = 1'b0;
    bias_valid     = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst            = 1'b1;
    data_in        = '0;
    bias           = '0;
    data_in_valid  = 1'b0;
    bias_valid     = 1'b0;
    data_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_floor();
    test_saturate();
    test_bias_only();
    test_stream();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
